// File: rtl/axis_join_arbiter_4_if.sv
// AXI4-Stream beat bundle shared by the four merge inputs and the merged output.
// master drives tdata/tlast/tvalid, slave drives tready.
interface axis_join_arbiter_4_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_join_arbiter_4.sv
// 4:1 AXI-Stream packet merge: round-robin or ordered 0->1->2->3 join, one bubble per packet.
// Registered output, 1-cycle latency; granted tready drops while the output register is stalled.
module axis_join_arbiter_4 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  join_enable,
  axis_join_arbiter_4_if.slave  s00_axis,
  axis_join_arbiter_4_if.slave  s01_axis,
  axis_join_arbiter_4_if.slave  s02_axis,
  axis_join_arbiter_4_if.slave  s03_axis,
  axis_join_arbiter_4_if.master m_axis
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            rr_last_q, rr_last_d;
  logic [1:0]            join_ptr_q, join_ptr_d;
  logic                  join_mode_q, join_mode_d;
  logic                  join_prev_q, join_prev_d;
  logic                  m_vld_q, m_vld_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;

  logic [3:0]            s_vld;
  logic [3:0]            s_last;
  logic [3:0]            s_rdy;
  logic [DATA_WIDTH-1:0] s_dat [4];

  logic                  out_free;
  logic                  accept;
  logic                  found;
  logic [1:0]            rr_idx;
  logic [1:0]            join_sel;

  assign s_vld  = {s03_axis.tvalid, s02_axis.tvalid, s01_axis.tvalid, s00_axis.tvalid};
  assign s_last = {s03_axis.tlast, s02_axis.tlast, s01_axis.tlast, s00_axis.tlast};
  assign s_dat[0] = s00_axis.tdata;
  assign s_dat[1] = s01_axis.tdata;
  assign s_dat[2] = s02_axis.tdata;
  assign s_dat[3] = s03_axis.tdata;

  assign s00_axis.tready = s_rdy[0];
  assign s01_axis.tready = s_rdy[1];
  assign s02_axis.tready = s_rdy[2];
  assign s03_axis.tready = s_rdy[3];

  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_dat_q;
  assign m_axis.tlast  = m_last_q;

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_vld_q || m_axis.tready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    join_ptr_d  = join_ptr_q;
    join_mode_d = join_mode_q;
    join_prev_d = join_prev_q;
    s_rdy       = '0;
    accept      = 1'b0;
    found       = 1'b0;
    rr_idx      = '0;
    join_sel    = '0;

    case (state_q)
      IDLE: begin
        join_prev_d = join_enable;
        if (join_enable) begin
          // A fresh enable restarts the reassembly sequence at input 0.
          join_sel   = join_prev_q ? join_ptr_q : 2'd0;
          join_ptr_d = join_sel;
          if (s_vld[join_sel]) begin
            grant_d     = join_sel;
            join_mode_d = 1'b1;
            state_d     = BUSY;
          end
        end else begin
          for (int i = 1; i <= 4; i++) begin
            rr_idx = rr_last_q + 2'(i);
            if (!found && s_vld[rr_idx]) begin
              found       = 1'b1;
              grant_d     = rr_idx;
              rr_last_d   = rr_idx;
              join_mode_d = 1'b0;
              state_d     = BUSY;
            end
          end
        end
      end
      BUSY: begin
        s_rdy[grant_q] = out_free;
        accept         = s_vld[grant_q] && out_free;
        if (accept && s_last[grant_q]) begin
          state_d = IDLE;
          if (join_mode_q) begin
            join_ptr_d = join_ptr_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_vld_d  = m_vld_q;
    m_dat_d  = m_dat_q;
    m_last_d = m_last_q;
    if (accept) begin
      m_vld_d  = 1'b1;
      m_dat_d  = s_dat[grant_q];
      m_last_d = s_last[grant_q];
    end else if (m_axis.tready) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_last_q   <= 2'd3;
      join_ptr_q  <= '0;
      join_mode_q <= 1'b0;
      join_prev_q <= 1'b0;
      m_vld_q     <= 1'b0;
      m_dat_q     <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      join_ptr_q  <= join_ptr_d;
      join_mode_q <= join_mode_d;
      join_prev_q <= join_prev_d;
      m_vld_q     <= m_vld_d;
      m_dat_q     <= m_dat_d;
      m_last_q    <= m_last_d;
    end
  end

endmodule
